// File: rtl/yarp_regfile_mp.sv
// yarp_regfile_mp: multi-port integer register file with optional write bypass and per-register pending scoreboard
// Ports:
//   clk, reset_n  rising-edge clock, asynchronous active-low reset
//   rd_addr_i     NUM_RD read addresses, port p at [p*AW +: AW]
//   rd_data_o     NUM_RD read data words, port p at [p*XLEN +: XLEN]
//   rd_busy_o     per read port: addressed register still awaits a producer
//   wr_en_i       per write port enable
//   wr_addr_i     NUM_WR write addresses
//   wr_data_i     NUM_WR write data words
//   alloc_en_i    mark alloc_addr_i pending (long-latency op issued)
//   alloc_addr_i  register to mark pending
//   flush_i       clear every pending bit
//   pending_o     raw pending vector
module yarp_regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_RD*AW-1:0]   rd_addr_i,
    output logic [NUM_RD*XLEN-1:0] rd_data_o,
    output logic [NUM_RD-1:0]      rd_busy_o,
    input  logic [NUM_WR-1:0]      wr_en_i,
    input  logic [NUM_WR*AW-1:0]   wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0] wr_data_i,
    input  logic                   alloc_en_i,
    input  logic [AW-1:0]          alloc_addr_i,
    input  logic                   flush_i,
    output logic [NUM_REGS-1:0]    pending_o
);
    logic [XLEN-1:0]     regs   [NUM_REGS];
    logic [XLEN-1:0]     wr_val [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] pend_nxt;

    // Per-register view of this cycle's writes; ascending port scan lets the highest port win.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = regs[r];
            for (int w = 0; w < NUM_WR; w++)
                if (wr_en_i[w] && wr_addr_i[w*AW +: AW] == AW'(r)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data_i[w*XLEN +: XLEN];
                end
            if (ZERO_REG && r == 0)
                wr_hit[r] = 1'b0;
            // flush > alloc > writeback > hold
            pend_nxt[r] = flush_i ? 1'b0 :
                          (alloc_en_i && alloc_addr_i == AW'(r) && !(ZERO_REG && r == 0)) ? 1'b1 :
                          wr_hit[r] ? 1'b0 : pending_o[r];
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] a;
        logic          z;
        logic          b;
        assign a = rd_addr_i[p*AW +: AW];
        assign z = ZERO_REG && a == '0;
        assign b = BYPASS && wr_hit[a];
        assign rd_data_o[p*XLEN +: XLEN] = z ? '0 : b ? wr_val[a] : regs[a];
        assign rd_busy_o[p] = !z && !b && pending_o[a];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
            pending_o <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                if (wr_hit[r])
                    regs[r] <= wr_val[r];
            pending_o <= pend_nxt;
        end
    end
endmodule

// File: tb/tb_yarp_regfile_mp.sv
// tb_yarp_regfile_mp: randomized and directed checks of yarp_regfile_mp against a behavioural model
module tb_yarp_regfile_mp;
    logic        clk;
    logic        reset_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        flush;
    logic [31:0] pend, pend_nb;

    int errors = 0;
    int checks = 0;

    logic [31:0] mregs [32];
    logic [31:0] mpend;

    yarp_regfile_mp #(.NUM_WR(2), .BYPASS(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .alloc_en_i(alloc_en),
        .alloc_addr_i(alloc_addr), .flush_i(flush), .pending_o(pend)
    );

    yarp_regfile_mp #(.NUM_WR(2), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb), .rd_busy_o(rd_busy_nb),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .alloc_en_i(alloc_en),
        .alloc_addr_i(alloc_addr), .flush_i(flush), .pending_o(pend_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        wr_en = '0;
        alloc_en = 1'b0;
        flush = 1'b0;
    endtask

    // Advance one rising edge and apply the architectural rules to the model.
    task automatic tick();
        logic [31:0] np;
        logic [4:0]  a;
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mregs[i] = '0;
            mpend = '0;
        end else begin
            np = mpend;
            for (int w = 0; w < 2; w++)
                if (wr_en[w]) begin
                    a = wr_addr[w*5 +: 5];
                    if (a != 0) mregs[a] = wr_data[w*32 +: 32];
                    np[a] = 1'b0;
                end
            if (alloc_en && alloc_addr != 0) np[alloc_addr] = 1'b1;
            if (flush) np = '0;
            mpend = np;
        end
        #1;
    endtask

    function automatic logic [31:0] m_data(input logic [4:0] a, input bit byp);
        logic [31:0] d;
        if (a == 0) return '0;
        d = mregs[a];
        if (byp)
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_addr[w*5 +: 5] == a) d = wr_data[w*32 +: 32];
        return d;
    endfunction

    function automatic logic m_busy(input logic [4:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp)
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_addr[w*5 +: 5] == a) return 1'b0;
        return mpend[a];
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mpend = '0;
        reset_n = 1'b0;
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_data = {32'h0, 32'hDEAD_BEEF};
        alloc_en = 1'b1;
        alloc_addr = 5'd5;
        flush = 1'b0;
        rd_addr = {5'd5, 5'd5};
        tick();
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        #1;
        checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        checks++; if (pend !== 32'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", pend); end
        checks++; if (pend_nb !== 32'h0) begin errors++; $display("FAIL reset_pending_nb got %h exp 0", pend_nb); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", rd_busy); end
    endtask

    task automatic test_write_read();
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd7};
        wr_data = {32'h0, 32'h1234_5678};
        tick();
        idle();
        rd_addr = {5'd7, 5'd7};
        #1;
        checks++; if (rd_data !== {2{32'h1234_5678}}) begin errors++; $display("FAIL wr_rd_both_ports got %h exp %h", rd_data, {2{32'h1234_5678}}); end
        checks++; if (rd_data_nb !== {2{32'h1234_5678}}) begin errors++; $display("FAIL wr_rd_nb got %h exp %h", rd_data_nb, {2{32'h1234_5678}}); end
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'h0, 32'hFFFF_FFFF};
        rd_addr = {5'd0, 5'd0};
        #1;
        checks++; if (rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL zero_bypass got %h exp 0", rd_data[31:0]); end
        tick();
        idle();
        #1;
        checks++; if (rd_data_nb[31:0] !== 32'h0) begin errors++; $display("FAIL zero_stored got %h exp 0", rd_data_nb[31:0]); end
    endtask

    task automatic test_bypass();
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd3};
        wr_data = {32'h0, 32'hA5A5_A5A5};
        rd_addr = {5'd0, 5'd3};
        #1;
        checks++; if (rd_data[31:0] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL bypass_on got %h exp a5a5a5a5", rd_data[31:0]); end
        checks++; if (rd_data_nb[31:0] !== 32'h0) begin errors++; $display("FAIL bypass_off got %h exp 0", rd_data_nb[31:0]); end
        tick();
        idle();
        #1;
        checks++; if (rd_data_nb[31:0] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL bypass_off_after got %h exp a5a5a5a5", rd_data_nb[31:0]); end
    endtask

    task automatic test_dual_write();
        wr_en = 2'b11;
        wr_addr = {5'd9, 5'd9};
        wr_data = {32'h2, 32'h1};
        rd_addr = {5'd9, 5'd9};
        #1;
        checks++; if (rd_data !== {32'h2, 32'h2}) begin errors++; $display("FAIL dual_bypass got %h exp 2 on both", rd_data); end
        tick();
        idle();
        #1;
        checks++; if (rd_data_nb !== {32'h2, 32'h2}) begin errors++; $display("FAIL dual_stored got %h exp 2 on both", rd_data_nb); end
    endtask

    task automatic test_scoreboard();
        alloc_en = 1'b1;
        alloc_addr = 5'd4;
        rd_addr = {5'd4, 5'd4};
        #1;
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL alloc_same_cycle_busy got %b exp 00", rd_busy); end
        tick();
        idle();
        #1;
        checks++; if (rd_busy !== 2'b11) begin errors++; $display("FAIL alloc_busy got %b exp 11", rd_busy); end
        checks++; if (pend !== 32'h10) begin errors++; $display("FAIL alloc_pending got %h exp 00000010", pend); end
        wr_en = 2'b10;
        wr_addr = {5'd4, 5'd0};
        wr_data = {32'h0000_CAFE, 32'h0};
        #1;
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL wb_busy_bypass got %b exp 00", rd_busy); end
        checks++; if (rd_busy_nb !== 2'b11) begin errors++; $display("FAIL wb_busy_nb got %b exp 11", rd_busy_nb); end
        checks++; if (rd_data[31:0] !== 32'h0000_CAFE) begin errors++; $display("FAIL wb_data got %h exp 0000cafe", rd_data[31:0]); end
        tick();
        idle();
        #1;
        checks++; if (pend[4] !== 1'b0 || pend_nb[4] !== 1'b0) begin errors++; $display("FAIL wb_clear got %b/%b exp 0", pend[4], pend_nb[4]); end
        alloc_en = 1'b1;
        alloc_addr = 5'd4;
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd4};
        wr_data = {32'h0, 32'h1111_2222};
        tick();
        idle();
        #1;
        checks++; if (pend[4] !== 1'b1) begin errors++; $display("FAIL alloc_beats_write got %b exp 1", pend[4]); end
        checks++; if (rd_busy !== 2'b11) begin errors++; $display("FAIL alloc_beats_write_busy got %b exp 11", rd_busy); end
    endtask

    task automatic test_flush();
        alloc_en = 1'b1;
        alloc_addr = 5'd2;
        tick();
        alloc_addr = 5'd6;
        tick();
        alloc_addr = 5'd10;
        tick();
        idle();
        #1;
        checks++; if (pend !== 32'h0000_0454) begin errors++; $display("FAIL pre_flush got %h exp 00000454", pend); end
        flush = 1'b1;
        alloc_en = 1'b1;
        alloc_addr = 5'd11;
        tick();
        idle();
        #1;
        checks++; if (pend !== 32'h0) begin errors++; $display("FAIL flush got %h exp 0", pend); end
        checks++; if (pend_nb !== 32'h0) begin errors++; $display("FAIL flush_nb got %h exp 0", pend_nb); end
    endtask

    task automatic test_random();
        logic [4:0] a;
        for (int c = 0; c < 400; c++) begin
            for (int w = 0; w < 2; w++) begin
                wr_en[w] = ($urandom_range(0, 2) == 0);
                wr_addr[w*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
                wr_data[w*32 +: 32] = $urandom;
            end
            alloc_en = ($urandom_range(0, 2) == 0);
            alloc_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < 2; p++)
                rd_addr[p*5 +: 5] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            #1;
            for (int p = 0; p < 2; p++) begin
                a = rd_addr[p*5 +: 5];
                checks++; if (rd_data[p*32 +: 32] !== m_data(a, 1'b1)) begin errors++; $display("FAIL rnd_data c%0d p%0d a%0d got %h exp %h", c, p, a, rd_data[p*32 +: 32], m_data(a, 1'b1)); end
                checks++; if (rd_data_nb[p*32 +: 32] !== m_data(a, 1'b0)) begin errors++; $display("FAIL rnd_data_nb c%0d p%0d a%0d got %h exp %h", c, p, a, rd_data_nb[p*32 +: 32], m_data(a, 1'b0)); end
                checks++; if (rd_busy[p] !== m_busy(a, 1'b1)) begin errors++; $display("FAIL rnd_busy c%0d p%0d a%0d got %b exp %b", c, p, a, rd_busy[p], m_busy(a, 1'b1)); end
                checks++; if (rd_busy_nb[p] !== m_busy(a, 1'b0)) begin errors++; $display("FAIL rnd_busy_nb c%0d p%0d a%0d got %b exp %b", c, p, a, rd_busy_nb[p], m_busy(a, 1'b0)); end
            end
            tick();
            checks++; if (pend !== mpend) begin errors++; $display("FAIL rnd_pending c%0d got %h exp %h", c, pend, mpend); end
            checks++; if (pend_nb !== mpend) begin errors++; $display("FAIL rnd_pending_nb c%0d got %h exp %h", c, pend_nb, mpend); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_dual_write();
        test_scoreboard();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
